// File: rtl/pipe_pkg.sv
// Shared constants and lane-slicing helpers for the pipeline stage register.
package pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NOSTOP  = 1'b0;
    localparam logic RST_ACT = 1'b0;

    // Lowest bit of a lane inside a flat multi-lane payload bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Highest bit of a lane inside a flat multi-lane payload bus.
    function automatic int lane_msb(input int lane, input int width);
        return lane * width + width - 1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bus between ctrl/upstream stage and the stage register, plus its status outputs.
interface pipe_stage_reg_if #(
    parameter int LANES     = 1,
    parameter int PAYLOAD_W = 128,
    parameter int STALL_W   = 6,
    parameter int CNT_W     = 16
);
    logic [STALL_W-1:0]         stall;
    logic                       flush;
    logic                       clr_cnt;
    logic [LANES*PAYLOAD_W-1:0] in_payload;
    logic [LANES-1:0]           in_valid;
    logic [LANES*PAYLOAD_W-1:0] out_payload;
    logic [LANES-1:0]           out_valid;
    logic [CNT_W-1:0]           hold_cnt;
    logic [CNT_W-1:0]           bubble_cnt;

    // Driver side: ctrl block plus upstream stage, observing the register outputs.
    modport master (
        output stall, flush, clr_cnt, in_payload, in_valid,
        input  out_payload, out_valid, hold_cnt, bubble_cnt
    );

    // The stage register itself.
    modport slave (
        input  stall, flush, clr_cnt, in_payload, in_valid,
        output out_payload, out_valid, hold_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst == RST_ACT || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane inter-stage pipeline register applying the hold/bubble/advance stall rule.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   LANES      = 1,
    parameter int                   PAYLOAD_W  = 128,
    parameter int                   STALL_W    = 6,
    parameter int                   STAGE_IDX  = 2,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0,
    parameter logic [PAYLOAD_W-1:0] KEEP_MASK  = '0,
    parameter int                   CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_reg_if.slave  bus
);
    logic up;
    logic dn;
    logic bubble_now;
    logic hold_now;

    assign up = (bus.stall[STAGE_IDX] == STOP);

    // The last stage has no downstream stall bit, so it can only bubble, never hold.
    generate
        if (STAGE_IDX == STALL_W - 1) begin : g_dn_last
            assign dn = NOSTOP;
        end else begin : g_dn_mid
            assign dn = (bus.stall[STAGE_IDX+1] == STOP);
        end
    endgenerate

    // Flush masks both counters; it is not a stall event.
    assign bubble_now = !bus.flush && up && !dn;
    assign hold_now   = !bus.flush && up && dn;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int LSB = lane_lsb(gi, PAYLOAD_W);
            localparam int MSB = lane_msb(gi, PAYLOAD_W);

            logic [PAYLOAD_W-1:0] pay_reg;
            logic                 valid_reg;

            // Per-lane state: full clear on reset, masked bubble on flush/bubble, load on advance, else hold.
            always_ff @(posedge clk) begin
                if (rst == RST_ACT) begin
                    pay_reg   <= BUBBLE_VAL;
                    valid_reg <= 1'b0;
                end else if (bus.flush || (up && !dn)) begin
                    pay_reg   <= (pay_reg & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK);
                    valid_reg <= 1'b0;
                end else if (!up) begin
                    pay_reg   <= bus.in_payload[MSB:LSB];
                    valid_reg <= bus.in_valid[gi];
                end
            end

            assign bus.out_payload[MSB:LSB] = pay_reg;
            assign bus.out_valid[gi]        = valid_reg;
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr_cnt),
        .inc   (hold_now),
        .count (bus.hold_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr_cnt),
        .inc   (bubble_now),
        .count (bus.bubble_cnt)
    );
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the OpenMIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries LANES independent payload lanes, each with a valid bit.
- Applies the global stall-vector rule: hold, bubble or advance. Adds synchronous flush, per-bit bubble-preserve masking and saturating stall/bubble performance counters.
- Sits between two adjacent pipeline stages, driven by the ctrl block's stall vector and flush line.

Parameters:
- LANES, 1, number of parallel payload lanes.
- PAYLOAD_W, 128, bits per lane payload.
- STALL_W, 6, width of the stall vector.
- STAGE_IDX, 2, index of this register's upstream stage in the stall vector; the downstream index is STAGE_IDX+1.
- BUBBLE_VAL, all-zero, payload value loaded on bubble or flush (PAYLOAD_W bits).
- KEEP_MASK, all-zero, payload bits set to 1 keep their current value on bubble or flush.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on clk rising edge only.
- stall  in  STALL_W  global stall vector; 1 = Stop, 0 = NoStop.
- flush  in  1  pipeline flush (exception/eret), 1 = flush.
- in_payload  in  LANES*PAYLOAD_W  upstream payload; lane i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- in_valid  in  LANES  upstream per-lane valid.
- out_payload  out  LANES*PAYLOAD_W  registered payload to the downstream stage.
- out_valid  out  LANES  registered per-lane valid.
- hold_cnt  out  CNT_W  saturating count of hold cycles.
- bubble_cnt  out  CNT_W  saturating count of bubble-insert cycles (flush cycles excluded).
- clr_cnt  in  1  synchronous clear of both counters.

Behaviour:
- Definitions:
  - up = stall[STAGE_IDX].
  - dn = stall[STAGE_IDX+1], or 0 when STAGE_IDX = STALL_W-1.
- Evaluation order (first match wins, once per rising clk edge):
  1. rst==0: every lane gets out_payload = BUBBLE_VAL (KEEP_MASK ignored; full clear), out_valid = 0, hold_cnt = 0, bubble_cnt = 0.
  2. flush==1: each lane's out_payload = (old & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK), out_valid = 0. Flush overrides any stall combination.
  3. up==1 and dn==0 (bubble): same payload/valid update as flush; bubble_cnt += 1.
  4. up==0 (advance): out_payload = in_payload, out_valid = in_valid, all lanes, all bits.
  5. up==1 and dn==1 (hold): out_payload and out_valid unchanged; hold_cnt += 1.
- Latency: exactly one cycle from input to output on advance. No combinational path from any input to any output.
- All lanes update identically under stall/flush; lanes differ only in data and valid.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - clr_cnt has priority over increment in the same cycle.
  - clr_cnt does not affect payload or valid.
  - Flush cycles increment neither counter.
- Stall vector contract: the ctrl block produces contiguous stalls (bit k set implies all lower bits set). The block behaves per the table regardless; up=0 with dn=1 is treated as advance.
- Reset mid-operation: reset dominates flush, stall and clr_cnt. The first non-reset edge follows the normal rules.
- BUBBLE_VAL must decode as NOP in the downstream stage (e.g. EXE_NOP_OP, WriteDisable); this is the integrator's responsibility.

Decomposition:
- Shared package pipe_pkg holds:
  - constants STOP=1'b1, NOSTOP=1'b0, RST_ACT=1'b0.
  - localparam helpers for lane slicing.
- One sub-module, sat_counter (parameter CNT_W; ports clk, rst, clr, inc, count), instantiated twice.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1, in_payload=0xDEAD... -> out_valid=0, out_payload=BUBBLE_VAL, both counters 0. After rst=1 with stall=0, the next edge gives out_payload=in_payload.
- Advance and hold: LANES=2, stall=0, push 0x11 then 0x22 -> out follows with 1-cycle latency. Then stall=6'b001111 for 3 cycles (STAGE_IDX=2) -> output frozen at 0x22, hold_cnt=3.
- Bubble with keep mask: KEEP_MASK = upper 32 bits (instruction field), stall=6'b000111 for one cycle -> out_valid=0, lower bits = BUBBLE_VAL, upper 32 bits retain the previous instruction, bubble_cnt=1.
- Flush priority: flush=1 with stall=6'b001111 -> bubble output (masked), hold_cnt and bubble_cnt unchanged.
- Saturation and clear: CNT_W=3, hold for 10 cycles -> hold_cnt=7. Assert clr_cnt while still holding -> next value 0.
- Last-stage index: STAGE_IDX=5, stall=6'b111111 -> bubble, since dn is treated as 0.
